// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle for rv32_mem_arbiter: fetch request/response, mem-stage
// request/response and the shared memory port.
// The slave modport is the arbiter's view. The master modport is the view
// of everything around it: requesters and memory.
interface rv32_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  instr_valid_in;
   logic                  instr_ready_out;
   logic [ADDR_WIDTH-1:0] instr_addr_in;
   logic                  instr_rvalid_out;
   logic [31:0]           instr_rdata_out;

   logic                  data_valid_in;
   logic                  data_ready_out;
   logic [ADDR_WIDTH-1:0] data_addr_in;
   logic                  data_write_in;
   logic [31:0]           data_wdata_in;
   logic [3:0]            data_wmask_in;
   logic                  data_rvalid_out;
   logic [31:0]           data_rdata_out;

   logic                  mem_valid_out;
   logic                  mem_ready_in;
   logic [ADDR_WIDTH-1:0] mem_addr_out;
   logic                  mem_write_out;
   logic [31:0]           mem_wdata_out;
   logic [3:0]            mem_wmask_out;
   logic [31:0]           mem_rdata_in;

   modport slave (
      input  instr_valid_in, instr_addr_in,
      input  data_valid_in, data_addr_in, data_write_in, data_wdata_in, data_wmask_in,
      input  mem_ready_in, mem_rdata_in,
      output instr_ready_out, instr_rvalid_out, instr_rdata_out,
      output data_ready_out, data_rvalid_out, data_rdata_out,
      output mem_valid_out, mem_addr_out, mem_write_out, mem_wdata_out, mem_wmask_out
   );

   modport master (
      output instr_valid_in, instr_addr_in,
      output data_valid_in, data_addr_in, data_write_in, data_wdata_in, data_wmask_in,
      output mem_ready_in, mem_rdata_in,
      input  instr_ready_out, instr_rvalid_out, instr_rdata_out,
      input  data_ready_out, data_rvalid_out, data_rdata_out,
      input  mem_valid_out, mem_addr_out, mem_write_out, mem_wdata_out, mem_wmask_out
   );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch and the mem stage. Only one transaction is outstanding at a
// time. By default data requests have strict priority over fetch.
// Optional macro RV32_ARB_FAIR_EN: after MAX_DATA_STREAK contested data grants,
// the next contested grant goes to fetch.
module rv32_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   rv32_mem_arbiter_if.slave      bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_I = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;

   if (MAX_DATA_STREAK < 1) begin : g_bad_streak
      $error("rv32_mem_arbiter: MAX_DATA_STREAK must be at least 1");
   end

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wmask_q, wmask_d;
   logic                  instr_rvalid_q, instr_rvalid_d;
   logic [31:0]           instr_rdata_q, instr_rdata_d;
   logic                  data_rvalid_q, data_rvalid_d;
   logic [31:0]           data_rdata_q, data_rdata_d;

   logic                  grant_data;
   logic                  grant_instr;
   logic                  force_instr;

`ifdef RV32_ARB_FAIR_EN
   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

   logic [STREAK_W-1:0] streak_q, streak_d;

   // Fetch is forced in once data has won MAX_DATA_STREAK contested grants in a row
   always_comb begin
      force_instr = (streak_q == STREAK_MAX) && bus.instr_valid_in && bus.data_valid_in;
   end

   // Count contested data grants (saturating). Any other grant restarts the streak
   always_comb begin
      streak_d = streak_q;
      if (grant_data && bus.instr_valid_in) begin
         streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
      end else if (grant_data || grant_instr) begin
         streak_d = '0;
      end
   end

   // Streak counter register
   always_ff @(posedge clk) begin
      if (reset) streak_q <= '0;
      else       streak_q <= streak_d;
   end
`else
   // Without the fairness option data always wins a contested grant
   always_comb begin
      force_instr = 1'b0;
   end
`endif

   // Grant decision: only taken in IDLE. Data wins unless fetch is being forced in
   always_comb begin
      grant_data  = (state_q == S_IDLE) && bus.data_valid_in && !force_instr;
      grant_instr = (state_q == S_IDLE) && bus.instr_valid_in && (!bus.data_valid_in || force_instr);
   end

   // Next-state, request latch and response generation
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      write_d        = write_q;
      wdata_d        = wdata_q;
      wmask_d        = wmask_q;
      instr_rvalid_d = 1'b0;
      instr_rdata_d  = instr_rdata_q;
      data_rvalid_d  = 1'b0;
      data_rdata_d   = data_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (grant_data) begin
               addr_d  = bus.data_addr_in;
               write_d = bus.data_write_in;
               wdata_d = bus.data_wdata_in;
               wmask_d = bus.data_wmask_in;
               state_d = S_BUSY_D;
            end else if (grant_instr) begin
               addr_d  = bus.instr_addr_in;
               write_d = 1'b0;
               wdata_d = 32'd0;
               wmask_d = 4'd0;
               state_d = S_BUSY_I;
            end
         end
         S_BUSY_I: begin
            if (bus.mem_ready_in) begin
               instr_rvalid_d = 1'b1;
               instr_rdata_d  = bus.mem_rdata_in;
               state_d        = S_IDLE;
            end
         end
         S_BUSY_D: begin
            if (bus.mem_ready_in) begin
               data_rvalid_d = 1'b1;
               data_rdata_d  = write_q ? 32'd0 : bus.mem_rdata_in;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched request and registered responses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         write_q        <= 1'b0;
         wdata_q        <= 32'd0;
         wmask_q        <= 4'd0;
         instr_rvalid_q <= 1'b0;
         instr_rdata_q  <= 32'd0;
         data_rvalid_q  <= 1'b0;
         data_rdata_q   <= 32'd0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         write_q        <= write_d;
         wdata_q        <= wdata_d;
         wmask_q        <= wmask_d;
         instr_rvalid_q <= instr_rvalid_d;
         instr_rdata_q  <= instr_rdata_d;
         data_rvalid_q  <= data_rvalid_d;
         data_rdata_q   <= data_rdata_d;
      end
   end

   // Output drive: readies are combinational grants held low during reset
   always_comb begin
      bus.instr_ready_out  = grant_instr && !reset;
      bus.data_ready_out   = grant_data && !reset;
      bus.instr_rvalid_out = instr_rvalid_q;
      bus.instr_rdata_out  = instr_rdata_q;
      bus.data_rvalid_out  = data_rvalid_q;
      bus.data_rdata_out   = data_rdata_q;
      bus.mem_valid_out    = (state_q != S_IDLE);
      bus.mem_addr_out     = addr_q;
      bus.mem_write_out    = write_q;
      bus.mem_wdata_out    = wdata_q;
      bus.mem_wmask_out    = wmask_q;
   end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed testbench for rv32_mem_arbiter. Inputs change 1ns after the rising
// edge and outputs are sampled 1ns after that. Honours RV32_ARB_FAIR_EN for the
// expected contention grant order.
module tb_rv32_mem_arbiter;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   rv32_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

   rv32_mem_arbiter #(.ADDR_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle: land 1ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs
   task automatic applyStimulus();
      #1;
   endtask

   // One counted comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed test sequence
   initial begin
      logic [9:0] exp_instr_grant;
      vectors     = 0;
      miscompares = 0;

      reset                  = 1'b1;
      bus.instr_valid_in     = 1'b0;
      bus.instr_addr_in      = 32'd0;
      bus.data_valid_in      = 1'b0;
      bus.data_addr_in       = 32'd0;
      bus.data_write_in      = 1'b0;
      bus.data_wdata_in      = 32'd0;
      bus.data_wmask_in      = 4'd0;
      bus.mem_ready_in       = 1'b0;
      bus.mem_rdata_in       = 32'd0;

      // Reset values; the ready is forced low while reset is high
      tick();
      tick();
      bus.instr_valid_in = 1'b1;
      applyStimulus();
      checkOutput("rst_mem_valid", {31'd0, bus.mem_valid_out}, 32'd0);
      checkOutput("rst_mem_addr", bus.mem_addr_out, 32'd0);
      checkOutput("rst_mem_wmask", {28'd0, bus.mem_wmask_out}, 32'd0);
      checkOutput("rst_instr_ready", {31'd0, bus.instr_ready_out}, 32'd0);
      checkOutput("rst_data_rvalid", {31'd0, bus.data_rvalid_out}, 32'd0);
      checkOutput("rst_data_rdata", bus.data_rdata_out, 32'd0);
      bus.instr_valid_in = 1'b0;
      reset = 1'b0;
      tick();

      // Single load, memory ready on its first cycle
      bus.data_valid_in = 1'b1;
      bus.data_addr_in  = 32'h100;
      bus.data_write_in = 1'b0;
      bus.mem_ready_in  = 1'b1;
      bus.mem_rdata_in  = 32'hDEADBEEF;
      applyStimulus();
      checkOutput("ld_data_ready", {31'd0, bus.data_ready_out}, 32'd1);
      checkOutput("ld_mem_valid_c0", {31'd0, bus.mem_valid_out}, 32'd0);
      tick();
      bus.data_valid_in = 1'b0;
      applyStimulus();
      checkOutput("ld_mem_valid_c1", {31'd0, bus.mem_valid_out}, 32'd1);
      checkOutput("ld_mem_addr", bus.mem_addr_out, 32'h100);
      checkOutput("ld_mem_write", {31'd0, bus.mem_write_out}, 32'd0);
      checkOutput("ld_rvalid_c1", {31'd0, bus.data_rvalid_out}, 32'd0);
      tick();
      bus.mem_ready_in = 1'b0;
      applyStimulus();
      checkOutput("ld_rvalid_c2", {31'd0, bus.data_rvalid_out}, 32'd1);
      checkOutput("ld_rdata_c2", bus.data_rdata_out, 32'hDEADBEEF);
      checkOutput("ld_mem_valid_c2", {31'd0, bus.mem_valid_out}, 32'd0);
      tick();
      checkOutput("ld_rvalid_c3", {31'd0, bus.data_rvalid_out}, 32'd0);
      checkOutput("ld_rdata_hold", bus.data_rdata_out, 32'hDEADBEEF);

      // Store with 3-cycle memory latency; request inputs scrambled after accept
      bus.data_valid_in = 1'b1;
      bus.data_addr_in  = 32'h20;
      bus.data_write_in = 1'b1;
      bus.data_wdata_in = 32'h12345678;
      bus.data_wmask_in = 4'b0011;
      applyStimulus();
      checkOutput("st_data_ready", {31'd0, bus.data_ready_out}, 32'd1);
      tick();
      bus.data_valid_in = 1'b0;
      bus.data_addr_in  = 32'hFFFF_FFFF;
      bus.data_wdata_in = 32'h0;
      bus.data_wmask_in = 4'b1111;
      bus.data_write_in = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) bus.mem_ready_in = 1'b1;
         applyStimulus();
         checkOutput($sformatf("st_mem_valid_c%0d", c), {31'd0, bus.mem_valid_out}, 32'd1);
         checkOutput($sformatf("st_mem_addr_c%0d", c), bus.mem_addr_out, 32'h20);
         checkOutput($sformatf("st_mem_write_c%0d", c), {31'd0, bus.mem_write_out}, 32'd1);
         checkOutput($sformatf("st_mem_wdata_c%0d", c), bus.mem_wdata_out, 32'h12345678);
         checkOutput($sformatf("st_mem_wmask_c%0d", c), {28'd0, bus.mem_wmask_out}, 32'h3);
         checkOutput($sformatf("st_rvalid_c%0d", c), {31'd0, bus.data_rvalid_out}, 32'd0);
         tick();
      end
      bus.mem_ready_in = 1'b0;
      applyStimulus();
      checkOutput("st_rvalid_c4", {31'd0, bus.data_rvalid_out}, 32'd1);
      checkOutput("st_rdata_c4", bus.data_rdata_out, 32'd0);
      checkOutput("st_instr_rvalid", {31'd0, bus.instr_rvalid_out}, 32'd0);
      tick();
      checkOutput("st_rvalid_c5", {31'd0, bus.data_rvalid_out}, 32'd0);

      // Contention: both requesters valid continuously, 1-cycle memory
`ifdef RV32_ARB_FAIR_EN
      exp_instr_grant = 10'b10000_10000;
`else
      exp_instr_grant = 10'b00000_00000;
`endif
      bus.instr_valid_in = 1'b1;
      bus.instr_addr_in  = 32'h400;
      bus.data_valid_in  = 1'b1;
      bus.data_addr_in   = 32'h800;
      bus.data_write_in  = 1'b0;
      bus.mem_ready_in   = 1'b1;
      for (int g = 0; g < 10; g++) begin
         applyStimulus();
         checkOutput($sformatf("ct_instr_ready_g%0d", g), {31'd0, bus.instr_ready_out}, {31'd0, exp_instr_grant[g]});
         checkOutput($sformatf("ct_data_ready_g%0d", g), {31'd0, bus.data_ready_out}, {31'd0, !exp_instr_grant[g]});
         tick();
         bus.mem_rdata_in = 32'hA000_0000 + 32'(g);
         applyStimulus();
         checkOutput($sformatf("ct_mem_addr_g%0d", g), bus.mem_addr_out, exp_instr_grant[g] ? 32'h400 : 32'h800);
         tick();
         checkOutput($sformatf("ct_instr_rvalid_g%0d", g), {31'd0, bus.instr_rvalid_out}, {31'd0, exp_instr_grant[g]});
         checkOutput($sformatf("ct_data_rvalid_g%0d", g), {31'd0, bus.data_rvalid_out}, {31'd0, !exp_instr_grant[g]});
         checkOutput($sformatf("ct_rdata_g%0d", g),
                     exp_instr_grant[g] ? bus.instr_rdata_out : bus.data_rdata_out,
                     32'hA000_0000 + 32'(g));
      end
      bus.instr_valid_in = 1'b0;
      bus.data_valid_in  = 1'b0;
      bus.mem_ready_in   = 1'b0;
      tick();

      // Back-to-back fetches: second accept lands on the first rvalid cycle
      bus.instr_valid_in = 1'b1;
      bus.instr_addr_in  = 32'h0;
      bus.mem_ready_in   = 1'b1;
      applyStimulus();
      checkOutput("bb_instr_ready_1", {31'd0, bus.instr_ready_out}, 32'd1);
      tick();
      bus.instr_addr_in = 32'h4;
      bus.mem_rdata_in  = 32'h0000_0013;
      applyStimulus();
      checkOutput("bb_mem_addr_1", bus.mem_addr_out, 32'h0);
      checkOutput("bb_mem_wmask_1", {28'd0, bus.mem_wmask_out}, 32'd0);
      tick();
      checkOutput("bb_instr_rvalid_1", {31'd0, bus.instr_rvalid_out}, 32'd1);
      checkOutput("bb_instr_rdata_1", bus.instr_rdata_out, 32'h0000_0013);
      checkOutput("bb_instr_ready_2", {31'd0, bus.instr_ready_out}, 32'd1);
      tick();
      bus.instr_valid_in = 1'b0;
      bus.mem_rdata_in   = 32'h0040_0093;
      applyStimulus();
      checkOutput("bb_mem_addr_2", bus.mem_addr_out, 32'h4);
      tick();
      bus.mem_ready_in = 1'b0;
      applyStimulus();
      checkOutput("bb_instr_rvalid_2", {31'd0, bus.instr_rvalid_out}, 32'd1);
      checkOutput("bb_instr_rdata_2", bus.instr_rdata_out, 32'h0040_0093);
      tick();

      // Reset while BUSY_D: the pending load must never answer
      bus.data_valid_in = 1'b1;
      bus.data_addr_in  = 32'h44;
      bus.data_write_in = 1'b0;
      applyStimulus();
      checkOutput("rm_data_ready", {31'd0, bus.data_ready_out}, 32'd1);
      tick();
      bus.data_valid_in = 1'b0;
      applyStimulus();
      checkOutput("rm_mem_valid_busy", {31'd0, bus.mem_valid_out}, 32'd1);
      reset = 1'b1;
      tick();
      checkOutput("rm_mem_valid_after", {31'd0, bus.mem_valid_out}, 32'd0);
      checkOutput("rm_mem_addr_after", bus.mem_addr_out, 32'd0);
      reset = 1'b0;
      bus.mem_ready_in = 1'b1;
      bus.mem_rdata_in = 32'hBAD0_BAD0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("rm_no_rvalid_%0d", c), {31'd0, bus.data_rvalid_out}, 32'd0);
      end

      // Spurious mem_ready_in while IDLE with no requests
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("sp_data_rvalid_%0d", c), {31'd0, bus.data_rvalid_out}, 32'd0);
         checkOutput($sformatf("sp_instr_rvalid_%0d", c), {31'd0, bus.instr_rvalid_out}, 32'd0);
         checkOutput($sformatf("sp_mem_valid_%0d", c), {31'd0, bus.mem_valid_out}, 32'd0);
      end
      bus.mem_ready_in = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
